pow_calc: RTL and testbench
===========================

Name: pow_calc

Overview:
- Sequential exponentiation unit that computes result = base^exp. It is the inverse of the team's combinational log2/bit-position encoder (get_pow).
- Takes an operand pair over a valid/ready input handshake and iterates right-to-left square-and-multiply, one exponent bit per cycle.
- Returns the low W bits of the true power plus an overflow flag over a valid/ready output handshake.
- Sits in the arithmetic datapath wherever an antilog/power value has to be rebuilt from an exponent.

Parameters:
- W, 8, width of base and result.
- EW, 3, width of exponent.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  unit can accept operands.
- base  input  W  unsigned base.
- exp  input  EW  unsigned exponent.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  W  (base^exp) mod 2^W.
- overflow  output  1  true base^exp >= 2^W.

Behaviour:
- One clock; reset is synchronous and active-low: rst_n sampled low at a rising clk edge resets the block. Inputs are ignored while rst_n is low.
- Reset values: state=IDLE, out_valid=0, result=0, overflow=0, internal acc/sq/e and flags cleared. in_ready=1 from the first cycle after reset.
- Reset mid-operation aborts the computation with no output. A result pending in DONE is discarded.
- in_ready = (state==IDLE). It is purely a function of state, with no combinational path from out_ready.
- States:
  - IDLE: in_valid&in_ready accepts the pair. Loads e=exp, acc=1, sq=base, sq_ovf=0, acc_ovf=0. Next state is RUN if exp!=0, else DONE with acc=1.
  - RUN: one cycle per exponent bit.
    - If e[0]: acc <= low W bits of acc*sq; acc_ovf <= acc_ovf | sq_ovf | (high W bits of acc*sq != 0).
    - Always: sq <= low W bits of sq*sq; sq_ovf <= sq_ovf | (high W bits of sq*sq != 0); e <= e>>1.
    - When (e>>1)==0, next state is DONE.
  - DONE: out_valid=1; result=acc, overflow=acc_ovf. Both are held stable while out_ready=0. On out_valid&out_ready, next state is IDLE and out_valid drops on the following cycle.
- Latency, with accept at edge k and L = bit length of exp (floor(log2 exp)+1):
  - exp=0: out_valid high after edge k+1.
  - exp!=0: out_valid high after edge k+1+L. Maximum is 4 cycles for EW=3.
- No new operand is accepted until the result handshake completes. Accept and result handshake never occur in the same cycle.
- Arithmetic:
  - Products are 2W bits wide internally; only the low W bits are stored.
  - result always equals the exact value mod 2^W, because arithmetic mod 2^W is consistent.
  - sq_ovf only contributes to overflow when sq is actually multiplied into acc. A final squaring whose value is unused never sets overflow.
- Boundaries:
  - 0^0 = 1, overflow=0.
  - 0^n = 0 for n>0, overflow=0.
  - x^1 = x, overflow=0 for all x.
  - 1^n = 1.
- in_valid asserted while not in IDLE is ignored; the source holds it per the handshake.

Test Plan:
- base=3, exp=4 -> result=81, overflow=0, out_valid 4 cycles after accept edge (L=3). base=2, exp=7 -> 128, overflow=0.
- base=3, exp=6 -> result=217 (729 mod 256), overflow=1. base=17, exp=2 -> result=33, overflow=1. base=3, exp=5 -> 243, overflow=0.
- base=16, exp=1 -> result=16, overflow=0: the internal square 256 overflows but is unused. base=255, exp=1 -> 255, overflow=0.
- base=0, exp=0 -> 1 after 1 cycle. base=0, exp=7 -> 0, overflow=0. base=255, exp=0 -> 1, overflow=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 and new operands -> result/overflow stable, in_ready=0, no second accept. Release out_ready -> one handshake, in_ready=1 the next cycle, then the queued pair is accepted.
- Reset: assert rst_n=0 for one edge during RUN (base=3, exp=7) -> next cycle IDLE, out_valid=0, result=0, overflow=0, in_ready=1. A fresh base=2, exp=3 then yields 8.

Source files
------------

// File: rtl/pow_calc_if.sv
// Operand/result handshake bundle for the pow_calc exponentiation unit.
// The master drives operands and consumes results. The slave is the calculator.
interface pow_calc_if #(
  parameter int W  = 8,
  parameter int EW = 3
);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  base;
  logic [EW-1:0] exp;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          overflow;

  modport master (
    output in_valid, base, exp, out_ready,
    input  in_ready, out_valid, result, overflow
  );

  modport slave (
    input  in_valid, base, exp, out_ready,
    output in_ready, out_valid, result, overflow
  );
endinterface

// File: rtl/pow_calc.sv
// pow_calc: sequential base^exp using right-to-left square-and-multiply.
// The unit consumes one exponent bit per RUN cycle.
// It returns the low W bits of the power and a flag that is set when the true power does not fit.
module pow_calc #(
  parameter int W  = 8,
  parameter int EW = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  pow_calc_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [W-1:0]  r_acc;
  logic [W-1:0]  r_sq;
  logic [EW-1:0] r_e;
  logic          r_acc_ovf;
  logic          r_sq_ovf;
  logic          r_out_valid;

  logic [W-1:0]  w_acc_next;
  logic [W-1:0]  w_sq_next;
  logic [EW-1:0] w_e_next;
  logic          w_acc_ovf_next;
  logic          w_sq_ovf_next;
  logic          w_out_valid_next;

  logic [2*W-1:0] w_acc_prod;
  logic [2*W-1:0] w_sq_prod;
  logic [EW-1:0]  w_e_shift;
  logic           w_accept;
  logic           w_deliver;

  // Both products are computed at full double width.
  // Any nonzero upper half means the true value no longer fits in W bits.
  assign w_acc_prod = {{W{1'b0}}, r_acc} * {{W{1'b0}}, r_sq};
  assign w_sq_prod  = {{W{1'b0}}, r_sq}  * {{W{1'b0}}, r_sq};
  assign w_e_shift  = r_e >> 1;

  assign w_accept  = bus.in_valid && (r_state == S_IDLE);
  assign w_deliver = r_out_valid && bus.out_ready;

  // in_ready depends on state only.
  // The result is presented only while out_valid is high, so the outputs read zero at all other times.
  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_out_valid ? r_acc : '0;
  assign bus.overflow  = r_out_valid ? r_acc_ovf : 1'b0;

  // Next-state and datapath update for IDLE/RUN/DONE (defaults hold every register).
  always_comb begin
    w_state_next     = r_state;
    w_acc_next       = r_acc;
    w_sq_next        = r_sq;
    w_e_next         = r_e;
    w_acc_ovf_next   = r_acc_ovf;
    w_sq_ovf_next    = r_sq_ovf;
    w_out_valid_next = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_e_next       = bus.exp;
          w_acc_next     = {{(W-1){1'b0}}, 1'b1};
          w_sq_next      = bus.base;
          w_acc_ovf_next = 1'b0;
          w_sq_ovf_next  = 1'b0;
          w_state_next   = (bus.exp != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        // sq_ovf reaches acc_ovf only when this square is actually multiplied in.
        // A trailing unused square therefore never sets the flag.
        if (r_e[0]) begin
          w_acc_next     = w_acc_prod[W-1:0];
          w_acc_ovf_next = r_acc_ovf | r_sq_ovf | (w_acc_prod[2*W-1:W] != '0);
        end
        w_sq_next     = w_sq_prod[W-1:0];
        w_sq_ovf_next = r_sq_ovf | (w_sq_prod[2*W-1:W] != '0);
        w_e_next      = w_e_shift;
        if (w_e_shift == '0) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        // out_valid goes high one cycle after DONE is entered.
        // It stays high until the consumer takes the result.
        w_out_valid_next = ~w_deliver;
        if (w_deliver) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath and output-valid registers; reset discards any computation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_sq        <= '0;
      r_e         <= '0;
      r_acc_ovf   <= 1'b0;
      r_sq_ovf    <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_acc       <= w_acc_next;
      r_sq        <= w_sq_next;
      r_e         <= w_e_next;
      r_acc_ovf   <= w_acc_ovf_next;
      r_sq_ovf    <= w_sq_ovf_next;
      r_out_valid <= w_out_valid_next;
    end
  end

endmodule

// File: tb/tb_pow_calc.sv
// Directed testbench for pow_calc: known powers, boundary cases, backpressure and mid-run reset.
module tb_pow_calc;
  localparam int W  = 8;
  localparam int EW = 3;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  pow_calc_if #(.W(W), .EW(EW)) bus ();

  pow_calc #(.W(W), .EW(EW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Waits up to 12 edges for out_valid and returns the number of edges counted since the accept edge.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 12) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run(input logic [W-1:0] b, input logic [EW-1:0] e,
                     input logic [W-1:0] exp_res, input logic exp_ovf, input int exp_lat);
    int lat;
    check("in_ready_before", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.base     = b;
    bus.exp      = e;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_valid(lat);
    check("latency",  32'(lat), 32'(exp_lat));
    check("result",   32'(bus.result), 32'(exp_res));
    check("overflow", 32'(bus.overflow), 32'(exp_ovf));
    $display("txn base=%0d exp=%0d result=%0d overflow=%0d latency=%0d",
             b, e, bus.result, bus.overflow, lat);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("out_valid_drop", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int lat;
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.base      = '0;
    bus.exp       = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    check("rst_in_ready",  32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result",    32'(bus.result), 32'd0);
    check("rst_overflow",  32'(bus.overflow), 32'd0);

    // Main function and boundaries
    run(8'd3,   3'd4, 8'd81,  1'b0, 4);
    run(8'd2,   3'd7, 8'd128, 1'b0, 4);
    run(8'd3,   3'd6, 8'd217, 1'b1, 4);
    run(8'd17,  3'd2, 8'd33,  1'b1, 3);
    run(8'd3,   3'd5, 8'd243, 1'b0, 4);
    run(8'd16,  3'd1, 8'd16,  1'b0, 2);
    run(8'd255, 3'd1, 8'd255, 1'b0, 2);
    run(8'd0,   3'd0, 8'd1,   1'b0, 1);
    run(8'd0,   3'd7, 8'd0,   1'b0, 4);
    run(8'd255, 3'd0, 8'd1,   1'b0, 1);
    run(8'd1,   3'd7, 8'd1,   1'b0, 4);

    // Backpressure: the result is held while out_ready is low, and a queued pair waits.
    bus.in_valid = 1'b1;
    bus.base     = 8'd3;
    bus.exp      = 3'd4;
    @(posedge clk);
    @(negedge clk);
    bus.base = 8'd2;
    bus.exp  = 3'd3;
    wait_valid(lat);
    check("bp_latency", 32'(lat), 32'd4);
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_result",    32'(bus.result), 32'd81);
      check("bp_overflow",  32'(bus.overflow), 32'd0);
      check("bp_in_ready",  32'(bus.in_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    $display("txn base=3 exp=4 result=%0d overflow=%0d held under backpressure", bus.result, bus.overflow);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("bp_release_valid", 32'(bus.out_valid), 32'd0);
    check("bp_release_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("bp_queued_accept", 32'(bus.in_ready), 32'd0);
    wait_valid(lat);
    check("bp_queued_latency", 32'(lat), 32'd3);
    check("bp_queued_result",  32'(bus.result), 32'd8);
    $display("txn base=2 exp=3 result=%0d overflow=%0d latency=%0d (queued)", bus.result, bus.overflow, lat);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;

    // Reset during RUN aborts the computation.
    bus.in_valid = 1'b1;
    bus.base     = 8'd3;
    bus.exp      = 3'd7;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_in_ready",  32'(bus.in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_result",    32'(bus.result), 32'd0);
    check("mid_rst_overflow",  32'(bus.overflow), 32'd0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("mid_rst_no_output", 32'(bus.out_valid), 32'd0);
    $display("txn base=3 exp=7 aborted by reset");
    run(8'd2, 3'd3, 8'd8, 1'b0, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
